reg_file_2r1w: RTL and testbench
================================

# reg_file_2r1w

Parametrised general-purpose register file for the RISC-V core, replacing the single-port load/store register block. It provides two registered read ports and one write port so the decode stage can fetch rs1 and rs2 in the same cycle while writeback updates rd. It also provides a hardware-sequenced clear operation. The block sits between decode (read side) and writeback (write side).

## Interface
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (2..64); AW = $clog2(NREGS) is a derived localparam
- ZERO_REG, 1, when 1 register 0 is hardwired to zero
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- we  in  1  write enable
- waddr  in  AW  write register index
- wdata  in  XLEN  write data
- re  in  1  read enable (both ports)
- raddr_a  in  AW  read port A index (rs1)
- raddr_b  in  AW  read port B index (rs2)
- rdata_a  out  XLEN  port A data, registered
- rdata_b  out  XLEN  port B data, registered
- rvalid  out  1  rdata_a/rdata_b valid, one-cycle pulse per accepted read
- clr_req  in  1  request a sequential clear of all registers
- busy  out  1  clear in progress; reads and writes are not accepted

## Operation
- Reset asserted: all registers = 0, rdata_a = rdata_b = 0, rvalid = 0, busy = 0, FSM = IDLE, clear counter = 0. All of these take effect immediately, without waiting for clk.
- Write: at an edge with we=1 and busy=0, reg[waddr] <= wdata.
  - Ignored if ZERO_REG=1 and waddr=0.
  - Ignored if waddr >= NREGS.
- Read: at an edge with re=1 and busy=0, rdata_a/b <= reg[raddr_a/b] and rvalid <= 1.
  - Index 0 with ZERO_REG=1 returns 0.
  - Index >= NREGS returns 0.
- Read not accepted (re=0 or busy=1): rvalid <= 0 and rdata_a/b hold their previous values.
- Same index on both ports is legal; both ports return the same value.
- FSM states:
  - IDLE: clr_req=1 -> CLEAR, counter <= 0, busy <= 1.
  - CLEAR: each edge sets reg[counter] <= 0 and counter <= counter+1. When counter = NREGS-1, the FSM returns to IDLE and busy <= 0.
- clr_req while in CLEAR is ignored. A clear cannot be cancelled except by reset.
- Reset mid-clear: the FSM returns to IDLE and all registers are zeroed asynchronously.

## Timing
- Read latency: 1 cycle. Address presented before edge k produces data and rvalid=1 after edge k.
- Back-to-back reads are accepted every cycle. rvalid stays high for consecutive accepted reads.
- Write-to-read, same cycle, same index: resolved by the REGFILE_BYPASS_EN setting (see Configuration).
- Write-to-read, next cycle: always returns the new value.
- clr_req=1 sampled at edge k:
  - busy = 1 after edge k.
  - Register i is cleared at edge k+1+i.
  - busy = 0 after edge k+NREGS.
  - The first read or write is accepted at edge k+NREGS+1.
- we=1 together with clr_req=1 in IDLE at edge k: the write is performed at edge k, then cleared by the sequence.
- re=1 together with clr_req=1 in IDLE at edge k: the read is accepted at edge k (rvalid=1 after edge k).

## Configuration
- REGFILE_BYPASS_EN defined: a read accepted at the same edge as a write to the same valid, non-zero index returns wdata (write-through forwarding). This applies independently to each port.
- REGFILE_BYPASS_EN undefined: that read returns the pre-write register contents, and the new value is visible from the following read.
- In both cases, a write to index 0 with ZERO_REG=1 never forwards.

## Structure
- Shared package regfile_pkg holds:
  - FSM state typedef (IDLE, CLEAR)
  - default XLEN and NREGS constants
  - the ZERO_VAL constant
- Natural sub-module: regfile_clear_seq. It contains the FSM and the clear counter, and outputs busy, clr_en and clr_idx.
- The register array, read registers and bypass muxes stay in reg_file_2r1w.

## Test plan
- Reset then read: reset pulse, then re=1 with raddr_a=5, raddr_b=31 -> rdata_a=0, rdata_b=0, rvalid=1 one cycle later.
- Write and read: write 0x0000_0002 to x0 and 0x0000_0003 to x4, then read a=0, b=4 -> rdata_a=0 (ZERO_REG), rdata_b=0x3.
- Same-cycle conflict: we=1, waddr=7, wdata=0xDEAD_BEEF, re=1, raddr_a=7 (x7 previously 0x11):
  - REGFILE_BYPASS_EN defined -> rdata_a=0xDEAD_BEEF.
  - Undefined -> rdata_a=0x11; next read -> 0xDEAD_BEEF.
- Clear sequence: fill x1..x31 with index values, pulse clr_req:
  - busy high for exactly NREGS=32 cycles.
  - Reads and writes issued while busy are dropped (rvalid=0, contents unchanged by the write).
  - After busy falls, reading all registers returns 0.
- Reset mid-clear: pulse reset 10 cycles into CLEAR -> busy=0 and rvalid=0 immediately; all registers read 0; a new write/read works on the next cycle.
- Parameter sweep: XLEN=64, NREGS=16. A write to waddr=15 reads back correctly. A clear takes 16 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the 2R1W register file.
// Holds the clear-sequencer state type and default sizing.
package regfile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_VAL  = 0;

endpackage

// File: rtl/regfile_clear_seq.sv
// Hardware clear sequencer: walks every register index once,
// holding busy high until the last index has been zeroed.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_idx
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // Next state: start on request, step the index, stop after the last one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and index registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q == CLEAR);
    assign clr_en  = (state_q == CLEAR);
    assign clr_idx = cnt_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with registered reads and a
// sequenced clear. REGFILE_BYPASS_EN enables write-through forwarding.
module reg_file_2r1w
    import regfile_pkg::*;
#(
    parameter int   XLEN     = XLEN_DEF,
    parameter int   NREGS    = NREGS_DEF,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr_a,
    input  logic [AW-1:0]   raddr_b,
    output logic [XLEN-1:0] rdata_a,
    output logic [XLEN-1:0] rdata_b,
    output logic            rvalid,
    input  logic            clr_req,
    output logic            busy
);

    localparam logic [XLEN-1:0] ZV = XLEN'(ZERO_VAL);

    // An index is backed by storage if it exists and is not hardwired zero.
    function automatic logic idx_live(input logic [AW-1:0] idx);
        return (int'(idx) < NREGS) && !(ZERO_REG && (idx == '0));
    endfunction

    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] mem_d [NREGS];
    logic [XLEN-1:0] rdata_a_q, rdata_a_d;
    logic [XLEN-1:0] rdata_b_q, rdata_b_d;
    logic            rvalid_q, rvalid_d;

    logic            clr_en;
    logic [AW-1:0]   clr_idx;
    logic            wr_ok;
    logic            rd_ok;
    logic            byp_a;
    logic            byp_b;
    logic [XLEN-1:0] val_a;
    logic [XLEN-1:0] val_b;

    regfile_clear_seq #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clr (
        .clk     (clk),
        .reset   (reset),
        .clr_req (clr_req),
        .busy    (busy),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    assign wr_ok = we && !busy && idx_live(waddr);
    assign rd_ok = re && !busy;

`ifdef REGFILE_BYPASS_EN
    assign byp_a = wr_ok && (waddr == raddr_a);
    assign byp_b = wr_ok && (waddr == raddr_b);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign val_a = !idx_live(raddr_a) ? ZV :
                   byp_a              ? wdata :
                                        mem_q[raddr_a];
    assign val_b = !idx_live(raddr_b) ? ZV :
                   byp_b              ? wdata :
                                        mem_q[raddr_b];

    // Array update: clear step or accepted write (never both, busy gates writes).
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_idx] = ZV;
        end
        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read capture: load on an accepted read, otherwise hold data and drop valid.
    always_comb begin
        rvalid_d  = rd_ok;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (rd_ok) begin
            rdata_a_d = val_a;
            rdata_b_d = val_b;
        end
    end

    // Storage and read registers, all zeroed immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= ZV;
            end
            rdata_a_q <= ZV;
            rdata_b_q <= ZV;
            rvalid_q  <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign rvalid  = rvalid_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: vector table plus clear,
// reset-mid-clear and a 64-bit/16-register instance.
module tb_reg_file_2r1w;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        we, re, clr_req;
    logic [4:0]  waddr, raddr_a, raddr_b;
    logic [31:0] wdata, rdata_a, rdata_b;
    logic        rvalid, busy;

    logic        we2, re2, clr2;
    logic [3:0]  waddr2, ra2, rb2;
    logic [63:0] wdata2, rd2a, rd2b;
    logic        rvalid2, busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int nb;

    always #5 clk = ~clk;

    reg_file_2r1w #(
        .XLEN     (32),
        .NREGS    (32),
        .ZERO_REG (1'b1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .rvalid  (rvalid),
        .clr_req (clr_req),
        .busy    (busy)
    );

    reg_file_2r1w #(
        .XLEN     (64),
        .NREGS    (16),
        .ZERO_REG (1'b1)
    ) u_dut64 (
        .clk     (clk),
        .reset   (reset),
        .we      (we2),
        .waddr   (waddr2),
        .wdata   (wdata2),
        .re      (re2),
        .raddr_a (ra2),
        .raddr_b (rb2),
        .rdata_a (rd2a),
        .rdata_b (rd2b),
        .rvalid  (rvalid2),
        .clr_req (clr2),
        .busy    (busy2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        we = 0; re = 0; clr_req = 0;
        waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 0;
        we2 = 0; re2 = 0; clr2 = 0;
        waddr2 = 0; wdata2 = 0; ra2 = 0; rb2 = 0;

        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset rvalid", 64'(rvalid), 64'd0);
        check("reset rdata_a", 64'(rdata_a), 64'd0);
        check("reset rdata_b", 64'(rdata_b), 64'd0);
        #11 reset = 1'b0;

        // we wa wd re ra rb | ev ea eb
        vt[0]  = '{0, 0,  32'h0,        1, 5, 31, 1, 32'h0, 32'h0};
        vt[1]  = '{1, 0,  32'h2,        0, 0, 0,  0, 32'h0, 32'h0};
        vt[2]  = '{1, 4,  32'h3,        0, 0, 0,  0, 32'h0, 32'h0};
        vt[3]  = '{0, 0,  32'h0,        1, 0, 4,  1, 32'h0, 32'h3};
        vt[4]  = '{1, 7,  32'h11,       0, 0, 0,  0, 32'h0, 32'h3};
        vt[5]  = '{1, 7,  32'hDEADBEEF, 1, 7, 4,  1,
                   BYP ? 32'hDEADBEEF : 32'h11, 32'h3};
        vt[6]  = '{0, 0,  32'h0,        1, 7, 7,  1,
                   32'hDEADBEEF, 32'hDEADBEEF};
        vt[7]  = '{1, 31, 32'hCAFE0031, 1, 4, 31, 1,
                   32'h3, BYP ? 32'hCAFE0031 : 32'h0};
        vt[8]  = '{0, 0,  32'h0,        1, 31, 31, 1,
                   32'hCAFE0031, 32'hCAFE0031};
        vt[9]  = '{1, 0,  32'hFFFF,     1, 0, 0,  1, 32'h0, 32'h0};
        vt[10] = '{1, 1,  32'hA5,       1, 1, 2,  1,
                   BYP ? 32'hA5 : 32'h0, 32'h0};
        vt[11] = '{0, 0,  32'h0,        0, 1, 2,  0,
                   BYP ? 32'hA5 : 32'h0, 32'h0};

        for (int i = 0; i < 12; i++) begin
            we      = vt[i].we;
            waddr   = vt[i].wa;
            wdata   = vt[i].wd;
            re      = vt[i].re;
            raddr_a = vt[i].ra;
            raddr_b = vt[i].rb;
            step();
            check($sformatf("vec%0d rvalid", i), 64'(rvalid), 64'(vt[i].ev));
            check($sformatf("vec%0d rdata_a", i), 64'(rdata_a), 64'(vt[i].ea));
            check($sformatf("vec%0d rdata_b", i), 64'(rdata_b), 64'(vt[i].eb));
        end

        // Fill x1..x31 with their own index.
        re = 0;
        for (int i = 1; i < 32; i++) begin
            we = 1; waddr = 5'(i); wdata = 32'(i);
            step();
        end

        // Clear request together with a read and a write.
        we = 1; waddr = 2; wdata = 32'h77;
        re = 1; raddr_a = 3; raddr_b = 5;
        clr_req = 1;
        step();
        check("clr read rvalid", 64'(rvalid), 64'd1);
        check("clr read a", 64'(rdata_a), 64'd3);
        check("clr read b", 64'(rdata_b), 64'd5);
        check("clr busy", 64'(busy), 64'd1);

        clr_req = 1;
        we = 1; waddr = 9; wdata = 32'hBAD;
        re = 1; raddr_a = 9; raddr_b = 9;
        nb = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            step();
            clr_req = 0;
            check("busy rvalid", 64'(rvalid), 64'd0);
            check("busy hold a", 64'(rdata_a), 64'd3);
        end
        check("clear cycles", 64'(nb), 64'd32);
        we = 0;

        for (int i = 0; i < 16; i++) begin
            re = 1; raddr_a = 5'(2 * i); raddr_b = 5'(2 * i + 1);
            step();
            check($sformatf("post-clr rvalid %0d", i), 64'(rvalid), 64'd1);
            check($sformatf("post-clr a x%0d", 2 * i), 64'(rdata_a), 64'd0);
            check($sformatf("post-clr b x%0d", 2 * i + 1), 64'(rdata_b), 64'd0);
        end

        // Reset in the middle of a clear.
        re = 0;
        we = 1; waddr = 5; wdata = 32'h55;
        step();
        we = 1; waddr = 6; wdata = 32'h66;
        step();
        we = 0; re = 1; raddr_a = 5; raddr_b = 6; clr_req = 1;
        step();
        check("pre-rst read a", 64'(rdata_a), 64'h55);
        clr_req = 0; re = 0;
        repeat (10) step();
        check("mid-clr busy", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'd0);
        check("rst rvalid", 64'(rvalid), 64'd0);
        check("rst rdata_a", 64'(rdata_a), 64'd0);
        check("rst rdata_b", 64'(rdata_b), 64'd0);
        #1 reset = 1'b0;

        we = 1; waddr = 5; wdata = 32'hABCD;
        @(posedge clk);
        #1;
        we = 0; re = 1; raddr_a = 5; raddr_b = 6;
        step();
        check("rst wr/rd rvalid", 64'(rvalid), 64'd1);
        check("rst wr/rd a", 64'(rdata_a), 64'hABCD);
        check("rst wr/rd b", 64'(rdata_b), 64'd0);

        for (int i = 0; i < 16; i++) begin
            re = 1; raddr_a = 5'(2 * i); raddr_b = 5'(2 * i + 1);
            step();
            check($sformatf("post-rst a x%0d", 2 * i), 64'(rdata_a),
                  (2 * i == 4) ? 64'h0 : 64'h0);
            check($sformatf("post-rst b x%0d", 2 * i + 1), 64'(rdata_b),
                  (2 * i + 1 == 5) ? 64'hABCD : 64'h0);
        end
        re = 0;

        // 64-bit, 16-register instance.
        we2 = 1; waddr2 = 15; wdata2 = 64'h1234_5678_9ABC_DEF0;
        step();
        we2 = 0; re2 = 1; ra2 = 15; rb2 = 0;
        step();
        check("w64 rvalid", 64'(rvalid2), 64'd1);
        check("w64 x15", rd2a, 64'h1234_5678_9ABC_DEF0);
        check("w64 x0", rd2b, 64'd0);

        re2 = 0; clr2 = 1;
        step();
        clr2 = 0;
        nb = 0;
        while (busy2 === 1'b1 && nb < 100) begin
            nb++;
            step();
        end
        check("w64 clear cycles", 64'(nb), 64'd16);
        re2 = 1; ra2 = 15; rb2 = 15;
        step();
        check("w64 x15 cleared", rd2a, 64'd0);
        re2 = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
